// File: rtl/multicycle_control.sv
// Multi-cycle ARMv8-subset control: FETCH/DECODE/EXEC/MEM/WB sequencing with
// variable-latency memory handshakes, dmem timeout trap and retired counter.
//
// state  | meaning
// FETCH  | request instruction, load IR when imem_ready
// DECODE | classify opcode, latch datapath controls
// EXEC   | branches retire here, memory ops go to MEM
// MEM    | hold data request until dmem_ready or timeout
// WB     | register writeback and PC+4
// TRAP   | sticky fault, only reset leaves
module multicycle_control #(
  parameter int OPCODE_W    = 11,
  parameter int RET_W       = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_zero,
  input  logic                i_imem_ready,
  input  logic                i_dmem_ready,
  output logic                o_imem_req,
  output logic                o_ir_write,
  output logic                o_pc_write,
  output logic                o_pc_src,
  output logic                o_dmem_read,
  output logic                o_dmem_write,
  output logic                o_reg_write,
  output logic                o_reg2loc,
  output logic                o_alusrc,
  output logic                o_mem2reg,
  output logic [3:0]          o_aluop,
  output logic [2:0]          o_signop,
  output logic [2:0]          o_state,
  output logic                o_trap,
  output logic [1:0]          o_trap_cause,
  output logic [RET_W-1:0]    o_retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_AND, C_ORR, C_ADDR, C_SUBR, C_ADDI, C_SUBI,
    C_MOVZ, C_B, C_CBZ, C_LDUR, C_STUR
  } cls_t;

  state_t           r_state;
  cls_t             r_cls;
  logic [3:0]       r_aluop;
  logic [2:0]       r_signop;
  logic             r_reg2loc;
  logic             r_alusrc;
  logic             r_mem2reg;
  logic             r_trap;
  logic [1:0]       r_trap_cause;
  logic [RET_W-1:0] r_retired;
  logic [TO_W-1:0]  r_to_cnt;

  cls_t       w_cls;
  logic [3:0] w_aluop;
  logic [2:0] w_signop;
  logic       w_reg2loc;
  logic       w_alusrc;
  logic       w_mem2reg;
  logic       w_to_hit;

  // Patterns are mutually exclusive; listed in priority order regardless.
  always_comb begin
    w_cls     = C_ILL;
    w_aluop   = 4'b0000;
    w_signop  = 3'b000;
    w_reg2loc = 1'b0;
    w_alusrc  = 1'b0;
    w_mem2reg = 1'b0;
    casez (i_opcode)
      11'b?0001010???: w_cls = C_AND;
      11'b?0101010???: begin w_cls = C_ORR;  w_aluop = 4'b0001; end
      11'b?0?01011???: begin w_cls = C_ADDR; w_aluop = 4'b0010; end
      11'b?1?01011???: begin w_cls = C_SUBR; w_aluop = 4'b0110; end
      11'b?0?10001???: begin w_cls = C_ADDI; w_aluop = 4'b0010; w_alusrc = 1'b1; end
      11'b?1?10001???: begin w_cls = C_SUBI; w_aluop = 4'b0110; w_alusrc = 1'b1; end
      11'b110100101??: begin
        w_cls    = C_MOVZ;
        w_aluop  = 4'b0111;
        w_alusrc = 1'b1;
        w_signop = {1'b1, i_opcode[1:0]};
      end
      11'b?00101?????: w_cls = C_B;
      11'b?011010????: begin
        w_cls = C_CBZ; w_reg2loc = 1'b1; w_aluop = 4'b0111; w_signop = 3'b011;
      end
      11'b??111000010: begin
        w_cls = C_LDUR; w_alusrc = 1'b1; w_mem2reg = 1'b1;
        w_aluop = 4'b0010; w_signop = 3'b001;
      end
      11'b??111000000: begin
        w_cls = C_STUR; w_reg2loc = 1'b1; w_alusrc = 1'b1;
        w_aluop = 4'b0010; w_signop = 3'b001;
      end
      default: ;
    endcase
  end

  // Counter has seen MEM_TIMEOUT-1 idle cycles; one more idle cycle hits the limit.
  assign w_to_hit = (MEM_TIMEOUT != 0) && (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_FETCH;
      r_cls        <= C_ILL;
      r_aluop      <= '0;
      r_signop     <= '0;
      r_reg2loc    <= 1'b0;
      r_alusrc     <= 1'b0;
      r_mem2reg    <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_cause <= 2'b00;
      r_retired    <= '0;
      r_to_cnt     <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (i_imem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_cls     <= w_cls;
          r_aluop   <= w_aluop;
          r_signop  <= w_signop;
          r_reg2loc <= w_reg2loc;
          r_alusrc  <= w_alusrc;
          r_mem2reg <= w_mem2reg;
          if (w_cls == C_ILL) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 2'b01;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_cls)
            C_B, C_CBZ: begin
              r_retired <= r_retired + RET_W'(1);
              r_state   <= S_FETCH;
            end
            C_LDUR, C_STUR: r_state <= S_MEM;
            default:        r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (i_dmem_ready) begin
            r_to_cnt <= '0;
            if (r_cls == C_LDUR) begin
              r_state <= S_WB;
            end else begin
              r_retired <= r_retired + RET_W'(1);
              r_state   <= S_FETCH;
            end
          end else if (w_to_hit) begin
            r_to_cnt     <= '0;
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 2'b10;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_WB: begin
          r_retired <= r_retired + RET_W'(1);
          r_state   <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes decode from registered state; forced low while reset is held.
  always_comb begin
    o_imem_req   = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    o_dmem_read  = 1'b0;
    o_dmem_write = 1'b0;
    o_reg_write  = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          o_ir_write = i_imem_ready;
        end
        S_EXEC: begin
          if (r_cls == C_B) begin
            o_pc_write = 1'b1;
            o_pc_src   = 1'b1;
          end else if (r_cls == C_CBZ) begin
            o_pc_write = 1'b1;
            o_pc_src   = i_zero;
          end
        end
        S_MEM: begin
          o_dmem_read  = (r_cls == C_LDUR);
          o_dmem_write = (r_cls == C_STUR);
          o_pc_write   = (r_cls == C_STUR) && i_dmem_ready;
        end
        S_WB: begin
          o_reg_write = 1'b1;
          o_pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_reg2loc    = r_reg2loc;
  assign o_alusrc     = r_alusrc;
  assign o_mem2reg    = r_mem2reg;
  assign o_aluop      = r_aluop;
  assign o_signop     = r_signop;
  assign o_state      = r_state;
  assign o_trap       = r_trap;
  assign o_trap_cause = r_trap_cause;
  assign o_retired    = r_retired;

endmodule
